i2s_tx_sequencer: RTL and testbench
===================================

Name: i2s_tx_sequencer

Overview:
- Stereo I2S transmit controller driven by the fractional-N audio timing generator's lrclk, load and shift strobes.
- Buffers producer samples in a small stereo FIFO and sequences the serial data line.
- Handles alignment to the left-channel slot, mute, underrun substitution and underrun accounting.
- Sits between the audio mixer output (valid/ready) and the I2S pin.

Parameters:
BITS_PER_SAMPLE, 16, bits per channel word; must match the timing generator
FIFO_DEPTH, 4, stereo frames buffered; power of two, >=2
UNDERRUN_REPEAT, 0, 1 = repeat last frame on underrun, 0 = send zeros
CNT_WIDTH, 16, width of saturating underrun counter

Ports:
clk  in  1  system clock, same domain as timing generator
reset  in  1  asynchronous, active-high
enable  in  1  run request; low flushes and idles
mute  in  1  substitute zero words while still consuming frames
s_valid  in  1  producer frame valid
s_ready  out  1  FIFO can accept a frame
s_left  in  BITS_PER_SAMPLE  left sample, two's complement
s_right  in  BITS_PER_SAMPLE  right sample
i2s_lrclk  in  1  word select from timing gen (0 = left)
load_strobe  in  1  1-cycle pulse, one BCLK edge after LR edge
shift_strobe  in  1  1-cycle pulse on BCLK falling edge
i2s_sdata  out  1  serial data, MSB first
fifo_level  out  $clog2(FIFO_DEPTH)+1  frames held
underrun  out  1  1-cycle pulse when a left load finds FIFO empty in RUN
underrun_count  out  CNT_WIDTH  saturating underrun total
frame_start  out  1  1-cycle pulse on every left-channel load in RUN

Behaviour:
- Reset values: s_ready=0, i2s_sdata=0, fifo_level=0, underrun=0, underrun_count=0, frame_start=0. State=IDLE, shift register=0, frame register=0.
- States:
  - IDLE: enable=0. FIFO is held empty, s_ready=0, sdata=0. Goes to SYNC when enable=1.
  - SYNC: FIFO accepts frames. sdata=0. Goes to RUN on the cycle load_strobe=1 with i2s_lrclk=0, and that cycle is processed as a RUN left load.
  - RUN: normal operation.
  - enable=0 in any state: next cycle IDLE, FIFO flushed, sdata=0. A partial word is discarded.
- s_ready = (state!=IDLE) && (fifo_level<FIFO_DEPTH), combinational from registered level.
  - Push on s_valid&&s_ready.
  - Push and pop in the same cycle: level unchanged, data order preserved.
  - Full: s_ready=0 even if a pop occurs that cycle.
- Left load (RUN, load_strobe=1, i2s_lrclk=0):
  - FIFO non-empty: pop head into frame register; shreg <= mute ? 0 : head.left; frame_start=1.
  - FIFO empty: underrun=1, frame_start=1, and underrun_count increments, saturating at all-ones.
    - UNDERRUN_REPEAT=1: frame register is unchanged and shreg <= mute ? 0 : frame.left.
    - UNDERRUN_REPEAT=0: frame register <= 0 and shreg <= 0.
- Right load (RUN, load_strobe=1, i2s_lrclk=1): shreg <= mute ? 0 : frame.right. No FIFO access.
- Shift: on shift_strobe without load_strobe, shreg <= shreg<<1 with zero fill. A bit counter saturates at BITS_PER_SAMPLE; after BITS_PER_SAMPLE shifts sdata stays 0 (pads slots when BCLK_PER_LRCLK > 2*BITS).
- Simultaneous load_strobe and shift_strobe: load wins, no shift.
- i2s_sdata = shreg[MSB] in RUN, registered (valid the cycle after a load/shift), else 0.
- Load-to-sdata latency: 1 clk.
- mute is sampled at load time only. Toggling it mid-word does not alter the word in flight.
- Strobes outside RUN are ignored, except the SYNC→RUN entry load.

Test Plan:
- Reset, enable=1, push L=0xA5C3 R=0x0F0F, drive 32-bit frame strobes -> first left load in SYNC enters RUN; sdata sequence is 1010010111000011 then 0000111100001111; frame_start pulses once; fifo_level 1→0.
- Push 4 frames with no strobes -> fifo_level=4, s_ready=0. 5th s_valid is held off. After one left load, level=3 and s_ready=1. Same-cycle push+pop at level 3 keeps level 3.
- RUN with FIFO empty, UNDERRUN_REPEAT=0 -> underrun pulses, count 0→1, sdata all zeros for the frame. With UNDERRUN_REPEAT=1 and last frame 0x8001/0x7FFE, the same words repeat.
- Force 65,540 underruns (CNT_WIDTH=16) -> underrun_count saturates at 0xFFFF.
- Assert mute before a left load with frame 0xFFFF/0xFFFF queued -> sdata all zeros, fifo_level decrements. mute asserted mid-left-word leaves the remaining left bits intact and zeros the right word.
- Deassert enable mid-word, re-enable during a right slot -> IDLE flushes FIFO (level 0), sdata 0. After re-enable, sdata stays 0 until the next left load, then RUN resumes. Async reset mid-frame returns all outputs to reset values immediately.

Source files
------------

// File: rtl/i2s_tx_sequencer.sv
// Stereo I2S transmit sequencer: buffers mixer frames in a small FIFO and shifts words out
// on the timing generator's load/shift strobes, with mute and underrun handling.
module i2s_tx_sequencer #(
    parameter int unsigned BITS_PER_SAMPLE = 16,
    parameter int unsigned FIFO_DEPTH      = 4,
    parameter bit          UNDERRUN_REPEAT = 1'b0,
    parameter int unsigned CNT_WIDTH       = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         enable_i,
    input  logic                         mute_i,
    input  logic                         s_valid_i,
    output logic                         s_ready_o,
    input  logic [BITS_PER_SAMPLE-1:0]   s_left_i,
    input  logic [BITS_PER_SAMPLE-1:0]   s_right_i,
    input  logic                         i2s_lrclk_i,
    input  logic                         load_strobe_i,
    input  logic                         shift_strobe_i,
    output logic                         i2s_sdata_o,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_level_o,
    output logic                         underrun_o,
    output logic [CNT_WIDTH-1:0]         underrun_count_o,
    output logic                         frame_start_o
);

    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned LvlW = PtrW + 1;
    localparam int unsigned CntW = $clog2(BITS_PER_SAMPLE + 1);
    localparam int unsigned B    = BITS_PER_SAMPLE;

    typedef enum logic [1:0] {StIdle, StSync, StRun} state_e;

    state_e          state_q, state_d;
    logic [2*B-1:0]  mem_q [FIFO_DEPTH];
    logic [PtrW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [LvlW-1:0] level_q, level_d;
    logic [B-1:0]    frame_l_q, frame_l_d, frame_r_q, frame_r_d;
    logic [B-1:0]    shreg_q, shreg_d;
    logic [CntW-1:0] bitcnt_q, bitcnt_d;
    logic            sdata_q, sdata_d;
    logic            underrun_q, underrun_d;
    logic            fstart_q, fstart_d;
    logic [CNT_WIDTH-1:0] urcnt_q, urcnt_d;

    logic           active, fifo_empty, left_load, right_load, shift, push, pop;
    logic [2*B-1:0] head;

    assign fifo_empty = (level_q == '0);
    assign s_ready_o  = (state_q != StIdle) && (level_q < LvlW'(FIFO_DEPTH));
    assign active     = enable_i && (state_q != StIdle);
    // SYNC accepts only the left load that starts the first frame
    assign left_load  = active && load_strobe_i && !i2s_lrclk_i;
    assign right_load = active && (state_q == StRun) && load_strobe_i && i2s_lrclk_i;
    assign shift      = active && (state_q == StRun) && shift_strobe_i && !load_strobe_i;
    assign push       = enable_i && s_valid_i && s_ready_o;
    assign pop        = left_load && !fifo_empty;
    assign head       = mem_q[rptr_q];

    always_comb begin
        state_d    = state_q;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        level_d    = level_q;
        frame_l_d  = frame_l_q;
        frame_r_d  = frame_r_q;
        shreg_d    = shreg_q;
        bitcnt_d   = bitcnt_q;
        urcnt_d    = urcnt_q;
        underrun_d = 1'b0;
        fstart_d   = 1'b0;

        if (!enable_i) begin
            state_d   = StIdle;
            wptr_d    = '0;
            rptr_d    = '0;
            level_d   = '0;
            frame_l_d = '0;
            frame_r_d = '0;
            shreg_d   = '0;
            bitcnt_d  = '0;
        end else begin
            if (state_q == StIdle) begin
                state_d = StSync;
            end
            if (left_load) begin
                state_d  = StRun;
                fstart_d = 1'b1;
                bitcnt_d = '0;
                if (!fifo_empty) begin
                    frame_l_d = head[2*B-1:B];
                    frame_r_d = head[B-1:0];
                    shreg_d   = mute_i ? '0 : head[2*B-1:B];
                end else begin
                    underrun_d = 1'b1;
                    if (urcnt_q != '1) begin
                        urcnt_d = urcnt_q + 1'b1;
                    end
                    if (UNDERRUN_REPEAT) begin
                        shreg_d = mute_i ? '0 : frame_l_q;
                    end else begin
                        frame_l_d = '0;
                        frame_r_d = '0;
                        shreg_d   = '0;
                    end
                end
            end else if (right_load) begin
                shreg_d  = mute_i ? '0 : frame_r_q;
                bitcnt_d = '0;
            end else if (shift) begin
                shreg_d = shreg_q << 1;
                if (bitcnt_q != CntW'(B)) begin
                    bitcnt_d = bitcnt_q + 1'b1;
                end
            end
            if (push) begin
                wptr_d = wptr_q + 1'b1;
            end
            if (pop) begin
                rptr_d = rptr_q + 1'b1;
            end
            level_d = level_q + LvlW'(push) - LvlW'(pop);
        end

        // Past the last data bit the slot is padded with zeros
        sdata_d = (state_d == StRun) && (bitcnt_d < CntW'(B)) && shreg_d[B-1];
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wptr_q] <= {s_left_i, s_right_i};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            wptr_q     <= '0;
            rptr_q     <= '0;
            level_q    <= '0;
            frame_l_q  <= '0;
            frame_r_q  <= '0;
            shreg_q    <= '0;
            bitcnt_q   <= '0;
            sdata_q    <= 1'b0;
            underrun_q <= 1'b0;
            fstart_q   <= 1'b0;
            urcnt_q    <= '0;
        end else begin
            state_q    <= state_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            level_q    <= level_d;
            frame_l_q  <= frame_l_d;
            frame_r_q  <= frame_r_d;
            shreg_q    <= shreg_d;
            bitcnt_q   <= bitcnt_d;
            sdata_q    <= sdata_d;
            underrun_q <= underrun_d;
            fstart_q   <= fstart_d;
            urcnt_q    <= urcnt_d;
        end
    end

    assign i2s_sdata_o      = sdata_q;
    assign fifo_level_o     = level_q;
    assign underrun_o       = underrun_q;
    assign underrun_count_o = urcnt_q;
    assign frame_start_o    = fstart_q;

endmodule

// File: tb/tb_i2s_tx_sequencer.sv
// Bench for i2s_tx_sequencer: two instances (zero-fill and repeat underrun) checked every cycle
// against a queue-based frame model, plus table vectors and directed corner sequences.
module tb_i2s_tx_sequencer;

    localparam int B = 16;
    localparam int D = 4;

    logic        clk = 1'b0, reset = 1'b1;
    logic        en = 1'b0, mute = 1'b0, sv = 1'b0, lr = 1'b0, ld = 1'b0, sh = 1'b0;
    logic [15:0] sl = '0, sr = '0;
    logic        ready [2], sdata [2], ur [2], fs [2];
    logic [2:0]  level [2];
    logic [15:0] cnt [2];

    int n_checks = 0, n_fails = 0;

    always #5 clk = ~clk;

    i2s_tx_sequencer #(.BITS_PER_SAMPLE(B), .FIFO_DEPTH(D), .UNDERRUN_REPEAT(1'b0),
                       .CNT_WIDTH(16)) u_dut0 (
        .clk(clk), .reset(reset), .enable_i(en), .mute_i(mute), .s_valid_i(sv),
        .s_ready_o(ready[0]), .s_left_i(sl), .s_right_i(sr), .i2s_lrclk_i(lr),
        .load_strobe_i(ld), .shift_strobe_i(sh), .i2s_sdata_o(sdata[0]),
        .fifo_level_o(level[0]), .underrun_o(ur[0]), .underrun_count_o(cnt[0]),
        .frame_start_o(fs[0])
    );

    i2s_tx_sequencer #(.BITS_PER_SAMPLE(B), .FIFO_DEPTH(D), .UNDERRUN_REPEAT(1'b1),
                       .CNT_WIDTH(16)) u_dut1 (
        .clk(clk), .reset(reset), .enable_i(en), .mute_i(mute), .s_valid_i(sv),
        .s_ready_o(ready[1]), .s_left_i(sl), .s_right_i(sr), .i2s_lrclk_i(lr),
        .load_strobe_i(ld), .shift_strobe_i(sh), .i2s_sdata_o(sdata[1]),
        .fifo_level_o(level[1]), .underrun_o(ur[1]), .underrun_count_o(cnt[1]),
        .frame_start_o(fs[1])
    );

    // Reference model: frames in a queue, the word in flight plus how many bits have gone out
    logic [31:0] mq [$];
    int          mode;              // 0 idle, 1 waiting for left slot, 2 streaming
    logic [15:0] m_cnt;
    logic        m_ur, m_fs;
    logic [31:0] cur [2];
    logic [15:0] word [2];
    int          sent [2];

    logic [63:0] cap [2];
    int          fs_seen;
    int          g_mute_at = -1, g_en_off_at = -1, g_en_on_at = -1;

    function automatic void model_reset();
        mq.delete();
        mode  = 0;
        m_cnt = '0;
        m_ur  = 1'b0;
        m_fs  = 1'b0;
        for (int i = 0; i < 2; i++) begin
            cur[i]  = '0;
            word[i] = '0;
            sent[i] = 0;
        end
    endfunction

    function automatic void model_step();
        bit          rdy, left, right, shf;
        logic [31:0] f;
        rdy  = (mode != 0) && (mq.size() < D);
        m_ur = 1'b0;
        m_fs = 1'b0;
        if (!en) begin
            mq.delete();
            mode = 0;
            for (int i = 0; i < 2; i++) begin
                cur[i]  = '0;
                word[i] = '0;
                sent[i] = 0;
            end
        end else begin
            left  = (mode != 0) && ld && !lr;
            right = (mode == 2) && ld && lr;
            shf   = (mode == 2) && sh && !ld;
            if (left) begin
                m_fs = 1'b1;
                mode = 2;
                if (mq.size() > 0) begin
                    f = mq.pop_front();
                    for (int i = 0; i < 2; i++) begin
                        cur[i]  = f;
                        word[i] = mute ? 16'h0 : f[31:16];
                    end
                end else begin
                    m_ur = 1'b1;
                    if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
                    cur[0]  = '0;
                    word[0] = '0;
                    word[1] = mute ? 16'h0 : cur[1][31:16];
                end
                for (int i = 0; i < 2; i++) sent[i] = 0;
            end else if (right) begin
                for (int i = 0; i < 2; i++) begin
                    word[i] = mute ? 16'h0 : cur[i][15:0];
                    sent[i] = 0;
                end
            end else if (shf) begin
                for (int i = 0; i < 2; i++) if (sent[i] < B) sent[i]++;
            end
            if (sv && rdy) mq.push_back({sl, sr});
            if (mode == 0) mode = 1;
        end
    endfunction

    function automatic logic exp_sdata(int i);
        if (mode == 2 && sent[i] < B) return word[i][B-1-sent[i]];
        return 1'b0;
    endfunction

    task automatic check_model();
        logic e_sd, e_rdy;
        int   e_lvl;
        for (int i = 0; i < 2; i++) begin
            e_sd  = exp_sdata(i);
            e_lvl = mq.size();
            e_rdy = (mode != 0) && (mq.size() < D);
            n_checks++;
            if (sdata[i] !== e_sd || int'(level[i]) != e_lvl || ready[i] !== e_rdy ||
                ur[i] !== m_ur || fs[i] !== m_fs || cnt[i] !== m_cnt) begin
                n_fails++;
                $display("FAIL model_cmp dut%0d t=%0t got sdata=%b level=%0d ready=%b ur=%b fs=%b cnt=%h, want sdata=%b level=%0d ready=%b ur=%b fs=%b cnt=%h",
                         i, $time, sdata[i], level[i], ready[i], ur[i], fs[i], cnt[i],
                         e_sd, e_lvl, e_rdy, m_ur, m_fs, m_cnt);
            end
        end
    endtask

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_fails++;
            $display("FAIL %s t=%0t got=%h want=%h", name, $time, got, want);
        end
    endtask

    task automatic step();
        bit was_strobe;
        was_strobe = ld || sh;
        @(posedge clk);
        if (reset) model_reset();
        else model_step();
        #1;
        check_model();
        if (was_strobe) for (int i = 0; i < 2; i++) cap[i] = {cap[i][62:0], sdata[i]};
        if (fs[0]) fs_seen++;
    endtask

    task automatic push(input logic [15:0] l, input logic [15:0] r);
        sv = 1'b1;
        sl = l;
        sr = r;
        step();
        sv = 1'b0;
    endtask

    task automatic frame(input int slot, input int per, input bit rnd);
        int pos;
        cap[0] = '0;
        cap[1] = '0;
        for (int lrv = 0; lrv < 2; lrv++) begin
            for (int b = 0; b < slot; b++) begin
                for (int p = 0; p < per; p++) begin
                    pos = lrv * slot + b;
                    lr  = lrv[0];
                    ld  = (p == 0 && b == 0);
                    sh  = (p == 0 && b != 0);
                    if (p == 0 && pos == g_mute_at) mute = 1'b1;
                    if (p == 0 && pos == g_en_off_at) en = 1'b0;
                    if (p == 0 && pos == g_en_on_at) en = 1'b1;
                    if (rnd) begin
                        sv   = ($urandom_range(0, 3) == 0);
                        sl   = 16'($urandom);
                        sr   = 16'($urandom);
                        mute = ($urandom_range(0, 7) == 0);
                        en   = ($urandom_range(0, 199) != 0);
                    end
                    step();
                end
            end
        end
        ld = 1'b0;
        sh = 1'b0;
    endtask

    typedef struct {
        bit          v;
        logic [15:0] l, r;
        bit          load, lrc;
        int          lvl;
        bit          rdy;
    } vec_t;

    initial begin
        #5000000;
        $display("FAIL watchdog t=%0t got=timeout want=finish", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        tbl [8];
        logic [15:0] cnt_before;

        model_reset();
        #3;
        for (int i = 0; i < 2; i++) begin
            chk("rst_sdata", 64'(sdata[i]), 64'h0);
            chk("rst_level", 64'(level[i]), 64'h0);
            chk("rst_ready", 64'(ready[i]), 64'h0);
            chk("rst_cnt",   64'(cnt[i]),   64'h0);
        end
        step();
        step();
        reset = 1'b0;

        // Basic frame: entry load in SYNC, MSB-first left then right word
        en = 1'b1;
        step();
        push(16'hA5C3, 16'h0F0F);
        chk("t1_level_before", 64'(level[0]), 64'h1);
        fs_seen = 0;
        frame(16, 2, 1'b0);
        chk("t1_bits_dut0", cap[0][31:0], 64'hA5C30F0F);
        chk("t1_bits_dut1", cap[1][31:0], 64'hA5C30F0F);
        chk("t1_frame_start", 64'(fs_seen), 64'h1);
        chk("t1_level_after", 64'(level[0]), 64'h0);
        frame(16, 2, 1'b0);
        chk("t1_underrun_zero", cap[0][31:0], 64'h0);
        chk("t1_underrun_rep", cap[1][31:0], 64'hA5C30F0F);
        chk("t1_cnt", 64'(cnt[0]), 64'h1);

        // FIFO fill, hold-off when full, same-cycle push and pop
        tbl[0] = '{1'b1, 16'h1111, 16'h2222, 1'b0, 1'b0, 1, 1'b1};
        tbl[1] = '{1'b1, 16'h3333, 16'h4444, 1'b0, 1'b0, 2, 1'b1};
        tbl[2] = '{1'b1, 16'h5555, 16'h6666, 1'b0, 1'b0, 3, 1'b1};
        tbl[3] = '{1'b1, 16'h7777, 16'h8888, 1'b0, 1'b0, 4, 1'b0};
        tbl[4] = '{1'b1, 16'h9999, 16'hAAAA, 1'b0, 1'b0, 4, 1'b0};
        tbl[5] = '{1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 3, 1'b1};
        tbl[6] = '{1'b1, 16'hBBBB, 16'hCCCC, 1'b1, 1'b0, 3, 1'b1};
        tbl[7] = '{1'b0, 16'h0000, 16'h0000, 1'b1, 1'b1, 3, 1'b1};
        for (int k = 0; k < 8; k++) begin
            sv = tbl[k].v;
            sl = tbl[k].l;
            sr = tbl[k].r;
            ld = tbl[k].load;
            lr = tbl[k].lrc;
            step();
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("tbl%0d_level", k), 64'(level[i]), 64'(tbl[k].lvl));
                chk($sformatf("tbl%0d_ready", k), 64'(ready[i]), 64'(tbl[k].rdy));
            end
        end
        sv = 1'b0;
        ld = 1'b0;
        frame(16, 1, 1'b0);
        chk("order_0", cap[0][31:0], 64'h55556666);
        frame(16, 1, 1'b0);
        chk("order_1", cap[0][31:0], 64'h77778888);
        frame(16, 1, 1'b0);
        chk("order_2", cap[1][31:0], 64'hBBBBCCCC);

        // Repeat-on-underrun of the last frame
        push(16'h8001, 16'h7FFE);
        frame(16, 2, 1'b0);
        chk("rep_first", cap[1][31:0], 64'h80017FFE);
        cnt_before = cnt[0];
        frame(16, 2, 1'b0);
        chk("rep_zero", cap[0][31:0], 64'h0);
        chk("rep_again", cap[1][31:0], 64'h80017FFE);
        chk("rep_cnt", 64'(cnt[0]), 64'(cnt_before + 16'd1));

        // Mute at load time, then mute raised mid left word
        push(16'hFFFF, 16'hFFFF);
        mute = 1'b1;
        frame(16, 2, 1'b0);
        chk("mute_bits", cap[0][31:0], 64'h0);
        chk("mute_level", 64'(level[0]), 64'h0);
        mute = 1'b0;
        push(16'hFFFF, 16'hFFFF);
        g_mute_at = 8;
        frame(16, 2, 1'b0);
        g_mute_at = -1;
        mute = 1'b0;
        chk("mute_mid_dut0", cap[0][31:0], 64'hFFFF0000);
        chk("mute_mid_dut1", cap[1][31:0], 64'hFFFF0000);

        // Disable mid-word, re-enable during the right slot
        push(16'h1234, 16'h5678);
        push(16'hABCD, 16'hEF01);
        g_en_off_at = 6;
        g_en_on_at  = 20;
        frame(16, 2, 1'b0);
        g_en_off_at = -1;
        g_en_on_at  = -1;
        chk("dis_level", 64'(level[0]), 64'h0);
        chk("dis_tail_bits", cap[0][15:0], 64'h0);
        push(16'h2468, 16'h1357);
        frame(16, 2, 1'b0);
        chk("reen_bits", cap[0][31:0], 64'h24681357);

        // Randomized traffic with padded slots
        for (int n = 0; n < 40; n++) begin
            frame($urandom_range(16, 20), $urandom_range(1, 3), 1'b1);
        end
        en   = 1'b1;
        mute = 1'b0;
        sv   = 1'b0;

        // Counter saturation: a left load every cycle with nothing queued
        ld = 1'b1;
        lr = 1'b0;
        repeat (65545) step();
        ld = 1'b0;
        chk("sat_cnt0", 64'(cnt[0]), 64'hFFFF);
        chk("sat_cnt1", 64'(cnt[1]), 64'hFFFF);
        chk("sat_pulse", 64'(ur[0]), 64'h1);

        // Asynchronous reset mid-frame
        push(16'hFFFF, 16'hFFFF);
        ld = 1'b1;
        step();
        ld = 1'b0;
        sh = 1'b1;
        repeat (3) step();
        sh = 1'b0;
        #2 reset = 1'b1;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("arst_sdata", 64'(sdata[i]), 64'h0);
            chk("arst_level", 64'(level[i]), 64'h0);
            chk("arst_ready", 64'(ready[i]), 64'h0);
            chk("arst_cnt",   64'(cnt[i]),   64'h0);
            chk("arst_fs",    64'(fs[i]),    64'h0);
            chk("arst_ur",    64'(ur[i]),    64'h0);
        end
        step();
        reset = 1'b0;
        step();
        push(16'hC0DE, 16'h0BAD);
        frame(16, 2, 1'b0);
        chk("post_rst_bits", cap[0][31:0], 64'hC0DE0BAD);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
